// File: rtl/vscale_dmem_rr_arbiter.sv
// Round-robin HASTI arbiter: NUM_CORES dmem masters onto the single p0 data
// port of the dual-port SRAM. Non-pipelined, so there is one address phase and
// then one data phase. An external index can steer the grant for formal runs.
module vscale_dmem_rr_arbiter #(
  parameter int NUM_CORES      = 2,
  parameter int CORE_IDX_WIDTH = 1,
  parameter int ADDR_W         = 32,
  parameter int BUS_W          = 32,
  parameter int SIZE_W         = 3,
  parameter int TRANS_W        = 2,
  parameter int RESP_W         = 1
) (
  input  logic                          hclk,
  input  logic                          hresetn,
  input  logic [NUM_CORES*ADDR_W-1:0]   core_haddr,
  input  logic [NUM_CORES-1:0]          core_hwrite,
  input  logic [NUM_CORES*SIZE_W-1:0]   core_hsize,
  input  logic [NUM_CORES*TRANS_W-1:0]  core_htrans,
  input  logic [NUM_CORES*BUS_W-1:0]    core_hwdata,
  output logic [NUM_CORES*BUS_W-1:0]    core_hrdata,
  output logic [NUM_CORES-1:0]          core_hready,
  output logic [NUM_CORES*RESP_W-1:0]   core_hresp,
  output logic [ADDR_W-1:0]             dmem_haddr,
  output logic                          dmem_hwrite,
  output logic [SIZE_W-1:0]             dmem_hsize,
  output logic [TRANS_W-1:0]            dmem_htrans,
  output logic [BUS_W-1:0]              dmem_hwdata,
  input  logic [BUS_W-1:0]              dmem_hrdata,
  input  logic                          dmem_hready,
  input  logic [RESP_W-1:0]             dmem_hresp,
  input  logic                          ext_sel_en,
  input  logic [CORE_IDX_WIDTH-1:0]     ext_next_core,
  output logic                          busy,
  output logic [CORE_IDX_WIDTH-1:0]     grant_idx
);

  localparam int                 IDX_SPACE     = 2 ** CORE_IDX_WIDTH;
  localparam logic [TRANS_W-1:0] HTRANS_IDLE   = TRANS_W'(0);
  localparam logic [TRANS_W-1:0] HTRANS_NONSEQ = TRANS_W'(2);
  localparam logic [RESP_W-1:0]  HRESP_OKAY    = RESP_W'(0);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic [CORE_IDX_WIDTH-1:0] owner_q, owner_d;
  logic [CORE_IDX_WIDTH-1:0] last_grant_q, last_grant_d;
  logic                      wdata_sel_valid_q, wdata_sel_valid_d;

  // Request vector padded to the full index space so any index is in range.
  logic [IDX_SPACE-1:0]      req;
  logic                      win_raw;
  logic                      win_vld;
  logic [CORE_IDX_WIDTH-1:0] win_idx;
  logic [CORE_IDX_WIDTH-1:0] addr_sel;
  int                        cand;

  // Decode per-core requests: only NONSEQ counts, SEQ/BUSY are never issued.
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      req[i] = (core_htrans[TRANS_W*i +: TRANS_W] == HTRANS_NONSEQ);
    end
  end

  // Pick the winner. The round-robin scan runs farthest-first so the nearest
  // requester after last_grant overwrites the others.
  always_comb begin
    win_raw = 1'b0;
    win_idx = '0;
    cand    = 0;
    if (ext_sel_en) begin
      if ((int'(ext_next_core) < NUM_CORES) && req[ext_next_core]) begin
        win_raw = 1'b1;
        win_idx = ext_next_core;
      end
    end else begin
      for (int k = NUM_CORES; k >= 1; k--) begin
        cand = (int'(last_grant_q) + k) % NUM_CORES;
        if (req[CORE_IDX_WIDTH'(cand)]) begin
          win_raw = 1'b1;
          win_idx = CORE_IDX_WIDTH'(cand);
        end
      end
    end
    // No grant may leak onto the bus while reset is held.
    win_vld  = win_raw && hresetn && (state_q == ST_IDLE);
    addr_sel = win_vld ? win_idx : '0;
  end

  // Bus steering: address mux, write-data mux and per-core responses.
  always_comb begin
    dmem_haddr  = core_haddr[0 +: ADDR_W];
    dmem_hwrite = core_hwrite[0];
    dmem_hsize  = core_hsize[0 +: SIZE_W];
    dmem_htrans = HTRANS_IDLE;
    dmem_hwdata = core_hwdata[0 +: BUS_W];
    core_hready = '1;
    core_hresp  = '0;
    core_hrdata = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      core_hrdata[BUS_W*i +: BUS_W] = dmem_hrdata;
      if (CORE_IDX_WIDTH'(i) == addr_sel) begin
        dmem_haddr  = core_haddr[ADDR_W*i +: ADDR_W];
        dmem_hwrite = core_hwrite[i];
        dmem_hsize  = core_hsize[SIZE_W*i +: SIZE_W];
      end
      if (wdata_sel_valid_q && (CORE_IDX_WIDTH'(i) == owner_q)) begin
        dmem_hwdata = core_hwdata[BUS_W*i +: BUS_W];
      end
    end
    if (win_vld) begin
      dmem_htrans = HTRANS_NONSEQ;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (req[i] && (CORE_IDX_WIDTH'(i) != win_idx)) begin
          core_hready[i] = 1'b0;
        end
      end
    end else if (state_q == ST_DATA) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (CORE_IDX_WIDTH'(i) == owner_q) begin
          core_hready[i]                  = dmem_hready;
          core_hresp[RESP_W*i +: RESP_W]  = dmem_hresp;
        end else begin
          core_hready[i]                  = !req[i];
          core_hresp[RESP_W*i +: RESP_W]  = HRESP_OKAY;
        end
      end
    end
    busy      = (state_q == ST_DATA);
    grant_idx = owner_q;
  end

  // Next-state: grant on a winner in IDLE, leave DATA when the SRAM is ready.
  always_comb begin
    state_d           = state_q;
    owner_d           = owner_q;
    last_grant_d      = last_grant_q;
    wdata_sel_valid_d = wdata_sel_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d           = ST_DATA;
          owner_d           = win_idx;
          last_grant_d      = win_idx;
          wdata_sel_valid_d = 1'b1;
        end
      end
      ST_DATA: begin
        if (dmem_hready) begin
          state_d           = ST_IDLE;
          wdata_sel_valid_d = 1'b0;
        end
      end
      default: begin
        state_d           = ST_IDLE;
        wdata_sel_valid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset gives core 0 first priority.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q           <= ST_IDLE;
      owner_q           <= '0;
      last_grant_q      <= CORE_IDX_WIDTH'(NUM_CORES - 1);
      wdata_sel_valid_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      owner_q           <= owner_d;
      last_grant_q      <= last_grant_d;
      wdata_sel_valid_q <= wdata_sel_valid_d;
    end
  end

endmodule

// File: tb/tb_vscale_dmem_rr_arbiter.sv
// Directed bench for the round-robin dmem arbiter with a small SRAM stub
// that supports configurable wait states and a forced error response.
module tb_vscale_dmem_rr_arbiter;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [31:0] c_addr  [2];
  logic        c_write [2];
  logic [2:0]  c_size  [2];
  logic [1:0]  c_trans [2];
  logic [31:0] c_wdata [2];

  logic [63:0] core_haddr;
  logic [1:0]  core_hwrite;
  logic [5:0]  core_hsize;
  logic [3:0]  core_htrans;
  logic [63:0] core_hwdata;
  logic [63:0] core_hrdata;
  logic [1:0]  core_hready;
  logic [1:0]  core_hresp;
  logic [31:0] dmem_haddr;
  logic        dmem_hwrite;
  logic [2:0]  dmem_hsize;
  logic [1:0]  dmem_htrans;
  logic [31:0] dmem_hwdata;
  logic [31:0] dmem_hrdata;
  logic        dmem_hready;
  logic        dmem_hresp;
  logic        ext_sel_en;
  logic        ext_next_core;
  logic        busy;
  logic        grant_idx;

  int errors = 0;
  int checks = 0;

  // SRAM stub state
  logic        s_dp;
  logic [31:0] s_addr;
  logic        s_write;
  int          s_wait;
  int          wait_cfg;
  logic        resp_force;
  logic [31:0] mem [0:255];

  assign core_haddr  = {c_addr[1], c_addr[0]};
  assign core_hwrite = {c_write[1], c_write[0]};
  assign core_hsize  = {c_size[1], c_size[0]};
  assign core_htrans = {c_trans[1], c_trans[0]};
  assign core_hwdata = {c_wdata[1], c_wdata[0]};

  assign dmem_hready = !s_dp || (s_wait == 0);
  assign dmem_hrdata = s_dp ? mem[s_addr[9:2]] : 32'h0;
  assign dmem_hresp  = s_dp && resp_force;

  always #5 hclk = ~hclk;

  vscale_dmem_rr_arbiter dut (
    .hclk          (hclk),
    .hresetn       (hresetn),
    .core_haddr    (core_haddr),
    .core_hwrite   (core_hwrite),
    .core_hsize    (core_hsize),
    .core_htrans   (core_htrans),
    .core_hwdata   (core_hwdata),
    .core_hrdata   (core_hrdata),
    .core_hready   (core_hready),
    .core_hresp    (core_hresp),
    .dmem_haddr    (dmem_haddr),
    .dmem_hwrite   (dmem_hwrite),
    .dmem_hsize    (dmem_hsize),
    .dmem_htrans   (dmem_htrans),
    .dmem_hwdata   (dmem_hwdata),
    .dmem_hrdata   (dmem_hrdata),
    .dmem_hready   (dmem_hready),
    .dmem_hresp    (dmem_hresp),
    .ext_sel_en    (ext_sel_en),
    .ext_next_core (ext_next_core),
    .busy          (busy),
    .grant_idx     (grant_idx)
  );

  // SRAM stub control: accept an address phase, then count down wait states.
  always @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      s_dp    <= 1'b0;
      s_addr  <= 32'h0;
      s_write <= 1'b0;
      s_wait  <= 0;
    end else begin
      if (s_dp) begin
        if (s_wait != 0) s_wait <= s_wait - 1;
        else             s_dp   <= 1'b0;
      end
      if ((dmem_htrans == 2'd2) && dmem_hready) begin
        s_dp    <= 1'b1;
        s_addr  <= dmem_haddr;
        s_write <= dmem_hwrite;
        s_wait  <= wait_cfg;
      end
    end
  end

  // SRAM stub storage: write commits at the end of the data phase.
  always @(posedge hclk) begin
    if (hresetn && s_dp && (s_wait == 0) && s_write) mem[s_addr[9:2]] <= dmem_hwdata;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic set_core(input int i, input logic [31:0] a, input logic w, input logic [1:0] t);
    c_addr[i]  = a;
    c_write[i] = w;
    c_trans[i] = t;
  endtask

  initial begin
    int cnt [2];
    int e;
    hresetn       = 1'b0;
    ext_sel_en    = 1'b0;
    ext_next_core = 1'b0;
    wait_cfg      = 0;
    resp_force    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      c_addr[i] = 32'h0; c_write[i] = 1'b0; c_size[i] = 3'd2; c_trans[i] = 2'd2; c_wdata[i] = 32'h0;
    end
    // Reset held with both cores requesting: nothing may reach the bus.
    #2;
    chk("rst_htrans", 64'(dmem_htrans), 64'd0);
    chk("rst_hready", 64'(core_hready), 64'h3);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant_idx), 64'd0);
    chk("rst_hresp", 64'(core_hresp), 64'd0);
    tick(); tick();
    set_core(0, 32'h0, 1'b0, 2'd0);
    set_core(1, 32'h0, 1'b0, 2'd0);
    hresetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("idle_htrans", 64'(dmem_htrans), 64'd0);
      chk("idle_hready", 64'(core_hready), 64'h3);
      chk("idle_busy", 64'(busy), 64'd0);
      tick();
    end

    // Core 0 write 0xDEADBEEF to 0x100.
    set_core(0, 32'h100, 1'b1, 2'd2);
    #1;
    chk("wr_addr_htrans", 64'(dmem_htrans), 64'd2);
    chk("wr_addr_haddr", 64'(dmem_haddr), 64'h100);
    chk("wr_addr_hwrite", 64'(dmem_hwrite), 64'd1);
    chk("wr_addr_hready", 64'(core_hready), 64'h3);
    tick();
    set_core(0, 32'h0, 1'b0, 2'd0);
    c_wdata[0] = 32'hDEADBEEF;
    #1;
    chk("wr_data_busy", 64'(busy), 64'd1);
    chk("wr_data_htrans", 64'(dmem_htrans), 64'd0);
    chk("wr_data_hwdata", 64'(dmem_hwdata), 64'hDEADBEEF);
    chk("wr_data_hready0", 64'(core_hready[0]), 64'd1);
    tick();
    #1;
    chk("wr_done_busy", 64'(busy), 64'd0);
    // Core 0 read back 0x100.
    set_core(0, 32'h100, 1'b0, 2'd2);
    #1;
    chk("rd_addr_htrans", 64'(dmem_htrans), 64'd2);
    tick();
    set_core(0, 32'h0, 1'b0, 2'd0);
    #1;
    chk("rd_data_busy", 64'(busy), 64'd1);
    chk("rd_data_hrdata", 64'(core_hrdata[31:0]), 64'hDEADBEEF);
    chk("rd_data_hready0", 64'(core_hready[0]), 64'd1);
    tick();
    #1;
    chk("rd_done_busy", 64'(busy), 64'd0);

    // Fresh reset, then both cores request continuously for 8 transfers.
    hresetn = 1'b0;
    tick();
    hresetn = 1'b1;
    cnt[0] = 0; cnt[1] = 0;
    set_core(0, 32'h200, 1'b0, 2'd2);
    set_core(1, 32'h300, 1'b0, 2'd2);
    for (int t = 0; t < 8; t++) begin
      e = t % 2;
      #1;
      chk("rr_addr_htrans", 64'(dmem_htrans), 64'd2);
      chk("rr_addr_haddr", 64'(dmem_haddr), 64'((e == 0 ? 32'h200 : 32'h300) + 32'(4 * cnt[e])));
      chk("rr_addr_hready", 64'(core_hready), (e == 0) ? 64'h1 : 64'h2);
      tick();
      #1;
      chk("rr_data_grant", 64'(grant_idx), 64'(e));
      chk("rr_data_busy", 64'(busy), 64'd1);
      chk("rr_data_hready", 64'(core_hready), (e == 0) ? 64'h1 : 64'h2);
      tick();
      cnt[e]++;
      c_addr[e] = (e == 0 ? 32'h200 : 32'h300) + 32'(4 * cnt[e]);
    end
    set_core(0, 32'h0, 1'b0, 2'd0);
    set_core(1, 32'h0, 1'b0, 2'd0);
    tick();

    // Core 1 transfer with 3 wait states while core 0 waits.
    wait_cfg = 3;
    set_core(1, 32'h340, 1'b0, 2'd2);
    #1;
    chk("ws_addr_haddr", 64'(dmem_haddr), 64'h340);
    tick();
    wait_cfg = 0;
    set_core(1, 32'h0, 1'b0, 2'd0);
    set_core(0, 32'h240, 1'b0, 2'd2);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("ws_busy", 64'(busy), 64'd1);
      chk("ws_grant", 64'(grant_idx), 64'd1);
      chk("ws_htrans", 64'(dmem_htrans), 64'd0);
      chk("ws_hready", 64'(core_hready), (k == 3) ? 64'h2 : 64'h0);
      tick();
    end
    #1;
    chk("ws_after_busy", 64'(busy), 64'd0);
    chk("ws_after_htrans", 64'(dmem_htrans), 64'd2);
    chk("ws_after_haddr", 64'(dmem_haddr), 64'h240);
    chk("ws_after_hready", 64'(core_hready), 64'h3);
    tick();
    set_core(0, 32'h0, 1'b0, 2'd0);
    #1;
    chk("ws_c0_grant", 64'(grant_idx), 64'd0);
    tick();

    // Forced steering to a non-requesting core blocks the grant.
    ext_sel_en    = 1'b1;
    ext_next_core = 1'b1;
    set_core(0, 32'h180, 1'b0, 2'd2);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("ext_block_htrans", 64'(dmem_htrans), 64'd0);
      chk("ext_block_hready", 64'(core_hready), 64'h3);
      tick();
    end
    ext_next_core = 1'b0;
    resp_force    = 1'b1;
    #1;
    chk("ext_go_htrans", 64'(dmem_htrans), 64'd2);
    tick();
    set_core(0, 32'h0, 1'b0, 2'd0);
    #1;
    chk("ext_go_busy", 64'(busy), 64'd1);
    chk("ext_go_grant", 64'(grant_idx), 64'd0);
    chk("err_hresp", 64'(core_hresp), 64'h1);
    tick();
    resp_force = 1'b0;
    ext_sel_en = 1'b0;
    #1;
    chk("err_done_busy", 64'(busy), 64'd0);

    // Reset asserted in the middle of a core 1 data phase.
    wait_cfg = 2;
    set_core(1, 32'h380, 1'b0, 2'd2);
    tick();
    #1;
    chk("mid_busy", 64'(busy), 64'd1);
    chk("mid_grant", 64'(grant_idx), 64'd1);
    #1;
    hresetn = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_grant", 64'(grant_idx), 64'd0);
    chk("mid_rst_htrans", 64'(dmem_htrans), 64'd0);
    chk("mid_rst_hready", 64'(core_hready), 64'h3);
    wait_cfg = 0;
    tick();
    hresetn = 1'b1;
    set_core(0, 32'h1C0, 1'b0, 2'd2);
    #1;
    chk("post_rst_haddr", 64'(dmem_haddr), 64'h1C0);
    chk("post_rst_hready", 64'(core_hready), 64'h1);
    tick();
    #1;
    chk("post_rst_grant", 64'(grant_idx), 64'd0);
    set_core(0, 32'h0, 1'b0, 2'd0);
    set_core(1, 32'h0, 1'b0, 2'd0);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
